// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage.
// Beat layout is {opa, opb, cmd, m, cin, inp_valid[1:0]}.
package alu_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATHER,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    localparam int unsigned CMD_MUL_INC = 9;
    localparam int unsigned CMD_MUL_SHL = 10;

    function automatic int beat_width(input int opw, input int cmdw);
        return 2 * opw + cmdw + 4;
    endfunction

    // Multiply commands only exist in arithmetic mode (m=1).
    function automatic logic is_mul(input logic m, input int unsigned cmd);
        return m && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Beat input handshake plus ALU-facing command bus of the issue stage.
// master = beat producer / ALU side, slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int OPWIDTH  = 8,
    parameter int CMDWIDTH = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [OPWIDTH-1:0]  in_opa;
    logic [OPWIDTH-1:0]  in_opb;
    logic [CMDWIDTH-1:0] in_cmd;
    logic                in_m;
    logic                in_cin;
    logic [1:0]          in_inp_valid;

    logic [OPWIDTH-1:0]  opa;
    logic [OPWIDTH-1:0]  opb;
    logic [CMDWIDTH-1:0] cmd;
    logic                m;
    logic                cin;
    logic                ce;
    logic [1:0]          inp_valid;
    logic                res_valid;
    logic                timeout_err;
    logic                drop;
    logic                busy;

    modport master (
        output in_valid, in_opa, in_opb, in_cmd, in_m, in_cin, in_inp_valid,
        input  in_ready, opa, opb, cmd, m, cin, ce, inp_valid,
        input  res_valid, timeout_err, drop, busy
    );

    modport slave (
        input  in_valid, in_opa, in_opb, in_cmd, in_m, in_cin, in_inp_valid,
        output in_ready, opa, opb, cmd, m, cin, ce, inp_valid,
        output res_valid, timeout_err, drop, busy
    );
endinterface

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO, async reset; head is visible combinationally on rd_dat.
// Caller guarantees push only when not full (or popping) and pop only when not empty.
module alu_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wr_dat;
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage ahead of the ALU: queues beats, merges split operands, holds ALU inputs for the command latency.
// Pop-to-ce is 1 cycle, res_valid follows ce by the latency; in_ready drops only when the FIFO is full and not popping.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int OPWIDTH  = 8,
    parameter int CMDWIDTH = 4,
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 16,
    parameter int ALU_LAT  = 1,
    parameter int MUL_LAT  = 2
) (
    input  logic           clk,
    input  logic           rst,
    alu_issue_ctrl_if.slave bus
);
    typedef struct packed {
        logic [OPWIDTH-1:0]  opa;
        logic [OPWIDTH-1:0]  opb;
        logic [CMDWIDTH-1:0] cmd;
        logic                m;
        logic                cin;
        logic [1:0]          iv;
    } beat_t;

    localparam int BW     = beat_width(OPWIDTH, CMDWIDTH);
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam int MAXLAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int LW     = $clog2(MAXLAT + 1);

    beat_t   in_beat;
    beat_t   head;
    beat_t   hold;
    state_t  state;
    logic    accept, push, pop, match, full, empty;
    logic [TW-1:0] tcnt;
    logic [LW-1:0] lcnt;

    logic [OPWIDTH-1:0]  opa_q, opb_q;
    logic [CMDWIDTH-1:0] cmd_q;
    logic                m_q, cin_q, ce_q, res_valid_q, timeout_err_q;
    logic [1:0]          iv_q;

    assign in_beat = {bus.in_opa, bus.in_opb, bus.in_cmd, bus.in_m, bus.in_cin, bus.in_inp_valid};

    // A partner must carry the same operation and exactly the operand still missing.
    assign match  = (state == ST_GATHER) && !empty && (head.cmd == hold.cmd) &&
                    (head.m == hold.m) && (head.iv == ~hold.iv);
    assign pop    = !empty && ((state == ST_IDLE) || match);
    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && (bus.in_inp_valid != 2'b00);

    assign bus.in_ready    = !full || pop;
    assign bus.drop        = accept && (bus.in_inp_valid == 2'b00);
    assign bus.busy        = (state != ST_IDLE) || !empty;
    assign bus.opa         = opa_q;
    assign bus.opb         = opb_q;
    assign bus.cmd         = cmd_q;
    assign bus.m           = m_q;
    assign bus.cin         = cin_q;
    assign bus.ce          = ce_q;
    assign bus.inp_valid   = iv_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.timeout_err = timeout_err_q;

    alu_issue_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_dat (in_beat),
        .pop    (pop),
        .rd_dat (head),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            hold          <= '0;
            tcnt          <= '0;
            lcnt          <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            cmd_q         <= '0;
            m_q           <= 1'b0;
            cin_q         <= 1'b0;
            iv_q          <= 2'b00;
            ce_q          <= 1'b0;
            res_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            res_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ce_q <= 1'b0;
                    if (!empty) begin
                        hold  <= head;
                        tcnt  <= '0;
                        state <= (head.iv == 2'b11) ? ST_ISSUE : ST_GATHER;
                    end
                end
                ST_GATHER: begin
                    if (match) begin
                        if (hold.iv[0]) hold.opb <= head.opb;
                        else            hold.opa <= head.opa;
                        hold.iv <= 2'b11;
                        state   <= ST_ISSUE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        state         <= ST_ISSUE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_ISSUE: begin
                    opa_q <= hold.opa;
                    opb_q <= hold.opb;
                    cmd_q <= hold.cmd;
                    m_q   <= hold.m;
                    cin_q <= hold.cin;
                    iv_q  <= hold.iv;
                    ce_q  <= 1'b1;
                    lcnt  <= is_mul(hold.m, 32'(hold.cmd)) ? LW'(MUL_LAT) : LW'(ALU_LAT);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lcnt <= LW'(1)) begin
                        res_valid_q <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        lcnt <= lcnt - LW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Operand/command issue stage that sits directly upstream of the ALU and drives its `opa`, `opb`, `cmd`, `m`, `cin`, `ce` and `inp_valid` inputs. It buffers incoming operation beats in a small FIFO and merges split-operand beats (OPA and OPB arriving separately) into one complete operation, bounded by a timeout. It issues one operation at a time and holds the ALU inputs stable for the command's latency. It also produces a `res_valid` strobe that marks the cycle in which the ALU outputs belong to the issued operation.

## Interface
- `OPWIDTH`, 8, operand width (matches ALU `opwidth`)
- `CMDWIDTH`, 4, command width (matches ALU `cmdwidth`)
- `DEPTH`, 4, input FIFO entries (power of 2, ≥2)
- `TIMEOUT`, 16, cycles to wait for the missing operand of a split beat
- `ALU_LAT`, 1, cycles from issue to valid ALU result, ordinary commands
- `MUL_LAT`, 2, cycles from issue to valid ALU result, multiply commands
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  FIFO not full
- `in_opa`, `in_opb`  in  OPWIDTH  operands
- `in_cmd`  in  CMDWIDTH  command
- `in_m`, `in_cin`  in  1  mode, carry-in
- `in_inp_valid`  in  2  bit0 = OPA present, bit1 = OPB present
- `opa`, `opb`  out  OPWIDTH  to ALU
- `cmd`  out  CMDWIDTH  to ALU
- `m`, `cin`, `ce`  out  1  to ALU
- `inp_valid`  out  2  to ALU
- `res_valid`  out  1  one-cycle strobe: ALU outputs correspond to the issued operation
- `timeout_err`  out  1  one-cycle strobe: a split beat issued without its partner
- `drop`  out  1  one-cycle strobe: a beat with `in_inp_valid=00` was discarded
- `busy`  out  1  FSM not IDLE or FIFO not empty

## Operation
- Accept a beat when `in_valid && in_ready`. A beat with `in_inp_valid=00` is not written to the FIFO; it pulses `drop` in the same cycle.
- FSM states: IDLE, GATHER, ISSUE, WAIT.
- IDLE: if the FIFO is non-empty, pop the head.
  - `11` → ISSUE.
  - `01` or `10` → GATHER, latching the beat and clearing the timeout counter.
- GATHER: when the FIFO head has the same `cmd`/`m` and supplies the missing operand (complementary `inp_valid`), pop it, merge to `11` → ISSUE.
- GATHER, non-matching head: it stays queued and the counter keeps running.
- GATHER, counter reaching `TIMEOUT-1`: → ISSUE with the partial `inp_valid` unchanged and pulse `timeout_err`. The ALU flags `err`.
- ISSUE: drive the ALU inputs and assert `ce`. Load the latency counter with `MUL_LAT` when `m=1` and `cmd` is 9 or 10, else `ALU_LAT`. → WAIT.
- WAIT: hold the ALU inputs and `ce` stable. Decrement the counter. At zero, pulse `res_valid` and → IDLE.
- The FIFO accepts beats in every state. Push and pop in the same cycle while full is legal; `in_ready` stays 1 in that case.
- One operation is in flight at a time; there is no back-to-back overlap.

## Timing
- Reset values (asynchronous): FSM = IDLE; FIFO empty; `in_ready`=1; `opa`, `opb`, `cmd`, `m`, `cin`, `inp_valid` = 0; `ce`=0; `res_valid`, `timeout_err`, `drop`, `busy` = 0.
- Complete beat into an empty FIFO:
  - accepted at edge N;
  - popped at edge N+1 (IDLE → ISSUE);
  - `ce` high from edge N+2;
  - `res_valid` high for the cycle after edge N+2+LAT.
- `ce` drops in the cycle after `res_valid`, unless the next operation's ISSUE follows immediately.
- `timeout_err` asserts in the same cycle that ISSUE is entered.
- `rst` asserted mid-operation clears all state and the FIFO immediately. Pending beats are lost and no `res_valid` is produced.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - full = MSBs differ and the lower bits are equal;
  - empty = pointers equal.

## Structure
- Shared package `alu_issue_pkg`:
  - state encoding enum (IDLE, GATHER, ISSUE, WAIT);
  - multiply command constants `CMD_MUL_INC`=9 and `CMD_MUL_SHL`=10;
  - the packed beat struct width `OPWIDTH*2+CMDWIDTH+4`.
- One sub-module: `alu_issue_fifo` (parameterised synchronous FIFO with async reset, full/empty flags).

## Test plan
- `in_inp_valid=11`, opa=8'h0A, opb=8'h05, cmd=0, m=1 → one `ce` window of `ALU_LAT` cycles, ALU inputs stable, `res_valid` once, ALU `res`=15.
- Beat `01` opa=8'h03, then 3 cycles later beat `10` opb=8'h04, cmd=9, m=1 → merged `inp_valid=11`, `ce` held `MUL_LAT` cycles, `res_valid` after `MUL_LAT`.
- Beat `01` with no partner → `timeout_err` exactly `TIMEOUT` cycles after entering GATHER, issued with `inp_valid=01`, ALU `err`=1.
- Push DEPTH+1 beats with no pop opportunity (FSM in WAIT) → `in_ready`=0 after DEPTH beats, no beat lost, issue order matches push order.
- Beat with `in_inp_valid=00` → `drop` pulse, FIFO count unchanged, no `ce`.
- `rst` pulsed during WAIT → all outputs at reset values within the same cycle, no `res_valid`, next beat after reset issues normally.
